// File: rtl/decode_operand_stage.sv
// Decode-side operand stage: bypassed register file, load-use interlock and
// ID/EX pipeline register with valid/ready handshake to EX.
module decode_operand_stage #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned REG_N        = 8,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned LOAD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_rs_sel,
  input  logic              in_rs_use,
  input  logic [SEL_W-1:0]  in_rt_sel,
  input  logic              in_rt_use,
  input  logic [SEL_W-1:0]  in_dst_sel,
  input  logic              in_dst_we,
  input  logic              in_is_load,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [SEL_W-1:0]  out_rs_sel,
  output logic [SEL_W-1:0]  out_rt_sel,
  output logic [SEL_W-1:0]  out_dst_sel,
  output logic              out_rs_use,
  output logic              out_rt_use,
  output logic              out_dst_we,
  output logic              out_is_load,
  output logic              err
);

  localparam int unsigned SEL_N = 2 ** SEL_W;

  // Array spans the full select space so any select indexes safely;
  // entries at or above REG_N are never written and always read as zero.
  logic [DATA_W-1:0] regs [SEL_N];
  logic [SEL_N-1:0]  legal;

  logic              hist_ld  [LOAD_BUBBLES];
  logic [SEL_W-1:0]  hist_dst [LOAD_BUBBLES];

  logic              adv;
  logic              hazard;
  logic              load_ok;
  logic              wb_ok;
  logic              rs_legal;
  logic              rt_legal;
  logic              bad_src;
  logic [DATA_W-1:0] rs_rd;
  logic [DATA_W-1:0] rt_rd;

  always_comb begin
    legal = '0;
    for (int unsigned i = 0; i < SEL_N; i++) begin
      legal[i] = (i < REG_N);
    end
  end

  always_comb begin
    wb_ok    = wb_we & legal[wb_sel];
    rs_legal = legal[in_rs_sel];
    rt_legal = legal[in_rt_sel];
    bad_src  = in_valid & ((in_rs_use & ~rs_legal) | (in_rt_use & ~rt_legal));

    rs_rd = '0;
    if (rs_legal) begin
      rs_rd = (wb_ok && wb_sel == in_rs_sel) ? wb_data : regs[in_rs_sel];
    end
    rt_rd = '0;
    if (rt_legal) begin
      rt_rd = (wb_ok && wb_sel == in_rt_sel) ? wb_data : regs[in_rt_sel];
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < LOAD_BUBBLES; i++) begin
      if (hist_ld[i] &&
          ((in_rs_use && hist_dst[i] == in_rs_sel) ||
           (in_rt_use && hist_dst[i] == in_rt_sel))) begin
        hazard = in_valid;
      end
    end
  end

  always_comb begin
    adv      = ~out_valid | out_ready;
    in_ready = flush | (adv & ~hazard);
    load_ok  = adv & in_valid & ~hazard & ~flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SEL_N; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_ok) begin
      regs[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((wb_we & ~legal[wb_sel]) | bad_src) begin
      err <= 1'b1;
    end
  end

  // Slot 0 mirrors the instruction entering the output register; bubbles shift in empty slots.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < LOAD_BUBBLES; i++) begin
        hist_ld[i]  <= 1'b0;
        hist_dst[i] <= '0;
      end
    end else if (adv) begin
      hist_ld[0]  <= load_ok & in_is_load & in_dst_we;
      hist_dst[0] <= load_ok ? in_dst_sel : '0;
      for (int unsigned i = 1; i < LOAD_BUBBLES; i++) begin
        hist_ld[i]  <= hist_ld[i-1];
        hist_dst[i] <= hist_dst[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rs_sel  <= '0;
      out_rt_sel  <= '0;
      out_dst_sel <= '0;
      out_rs_use  <= 1'b0;
      out_rt_use  <= 1'b0;
      out_dst_we  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      if (load_ok) begin
        out_valid   <= 1'b1;
        out_rs_data <= rs_rd;
        out_rt_data <= rt_rd;
        out_imm     <= in_imm;
        out_pc      <= in_pc;
        out_rs_sel  <= in_rs_sel;
        out_rt_sel  <= in_rt_sel;
        out_dst_sel <= in_dst_sel;
        out_rs_use  <= in_rs_use;
        out_rt_use  <= in_rt_use;
        out_dst_we  <= in_dst_we;
        out_is_load <= in_is_load;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      // Held instruction keeps operands current with writebacks that land while stalled.
      if (wb_ok && out_rs_use && out_rs_sel == wb_sel) begin
        out_rs_data <= wb_data;
      end
      if (wb_ok && out_rt_use && out_rt_sel == wb_sel) begin
        out_rt_data <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_decode_operand_stage.sv
// Directed bench: three stage instances (8 regs/1 bubble, 8 regs/2 bubbles,
// 6 regs/1 bubble) share one stimulus stream; each task checks its scenario.
module tb_decode_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_rs_sel, in_rt_sel, in_dst_sel;
  logic        in_rs_use, in_rt_use, in_dst_we, in_is_load;
  logic [15:0] in_imm, in_pc;
  logic        flush;
  logic        wb_we;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        out_ready;

  logic        ir   [3];
  logic        ov   [3];
  logic [15:0] rsd  [3];
  logic [15:0] rtd  [3];
  logic [15:0] immo [3];
  logic [15:0] pco  [3];
  logic [2:0]  rss  [3];
  logic [2:0]  rts  [3];
  logic [2:0]  dsts [3];
  logic        rsu  [3];
  logic        rtu  [3];
  logic        dwe  [3];
  logic        isl  [3];
  logic        er   [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned RN = (g == 2) ? 6 : 8;
    localparam int unsigned LB = (g == 1) ? 2 : 1;
    decode_operand_stage #(
      .DATA_W(16), .REG_N(RN), .SEL_W(3), .LOAD_BUBBLES(LB)
    ) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(ir[g]),
      .in_rs_sel(in_rs_sel), .in_rs_use(in_rs_use),
      .in_rt_sel(in_rt_sel), .in_rt_use(in_rt_use),
      .in_dst_sel(in_dst_sel), .in_dst_we(in_dst_we), .in_is_load(in_is_load),
      .in_imm(in_imm), .in_pc(in_pc),
      .flush(flush),
      .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
      .out_valid(ov[g]), .out_ready(out_ready),
      .out_rs_data(rsd[g]), .out_rt_data(rtd[g]),
      .out_imm(immo[g]), .out_pc(pco[g]),
      .out_rs_sel(rss[g]), .out_rt_sel(rts[g]), .out_dst_sel(dsts[g]),
      .out_rs_use(rsu[g]), .out_rt_use(rtu[g]),
      .out_dst_we(dwe[g]), .out_is_load(isl[g]),
      .err(er[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_rs_sel = 0; in_rt_sel = 0; in_dst_sel = 0;
    in_rs_use = 0; in_rt_use = 0; in_dst_we = 0; in_is_load = 0;
    in_imm = 0; in_pc = 0; flush = 0; wb_we = 0; wb_sel = 0; wb_data = 0;
  endtask

  task automatic set_instr(input logic [2:0] rs, input logic rsu_i,
                           input logic [2:0] rt, input logic rtu_i,
                           input logic [2:0] dst, input logic we, input logic ld);
    in_valid = 1; in_rs_sel = rs; in_rs_use = rsu_i; in_rt_sel = rt; in_rt_use = rtu_i;
    in_dst_sel = dst; in_dst_we = we; in_is_load = ld;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (ov[g] !== 1'b0 || er[g] !== 1'b0 || rsd[g] !== 16'h0 || rtd[g] !== 16'h0 ||
          immo[g] !== 16'h0 || pco[g] !== 16'h0 || dsts[g] !== 3'd0 || isl[g] !== 1'b0) begin
        $display("FAIL reset_state dut%0d: valid=%b err=%b rs=%h rt=%h imm=%h pc=%h, required all 0",
                 g, ov[g], er[g], rsd[g], rtd[g], immo[g], pco[g]);
        miscompares++;
      end
    end
    for (int r = 0; r < 8; r++) begin
      set_instr(3'(r), 1, 3'(r), 1, 3'd0, 0, 0);
      in_imm = 16'(16'h100 + r);
      in_pc  = 16'(16'h200 + 2 * r);
      step();
      vectors++;
      if (ov[0] !== 1'b1 || rsd[0] !== 16'h0 || rtd[0] !== 16'h0 ||
          immo[0] !== 16'(16'h100 + r) || pco[0] !== 16'(16'h200 + 2 * r)) begin
        $display("FAIL reset_read R%0d: valid=%b rs=%h rt=%h imm=%h pc=%h, required 1/0000/0000/%h/%h",
                 r, ov[0], rsd[0], rtd[0], immo[0], pco[0], 16'(16'h100 + r), 16'(16'h200 + 2 * r));
        miscompares++;
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_bypass();
    wb_we = 1; wb_sel = 3'd3; wb_data = 16'h1234;
    set_instr(3'd3, 1, 3'd0, 1, 3'd1, 1, 0);
    step();
    vectors++;
    if (ov[0] !== 1'b1 || rsd[0] !== 16'h1234 || rtd[0] !== 16'h0) begin
      $display("FAIL wb_bypass: valid=%b rs=%h rt=%h, required 1/1234/0000", ov[0], rsd[0], rtd[0]);
      miscompares++;
    end
    wb_we = 0;
    set_instr(3'd0, 1, 3'd3, 1, 3'd1, 1, 0);
    step();
    vectors++;
    if (rtd[0] !== 16'h1234 || rts[0] !== 3'd3) begin
      $display("FAIL wb_stored: rt=%h sel=%0d, required 1234 sel 3", rtd[0], rts[0]);
      miscompares++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_load_use();
    set_instr(3'd1, 1, 3'd0, 0, 3'd2, 1, 1);
    step();
    vectors++;
    if (ov[0] !== 1'b1 || isl[0] !== 1'b1 || dsts[0] !== 3'd2) begin
      $display("FAIL load_issue: valid=%b is_load=%b dst=%0d, required 1/1/2", ov[0], isl[0], dsts[0]);
      miscompares++;
    end
    set_instr(3'd2, 1, 3'd2, 1, 3'd4, 1, 0);
    #1;
    vectors++;
    if (ir[0] !== 1'b0 || ir[1] !== 1'b0) begin
      $display("FAIL load_use_stall: in_ready=%b/%b, required 0/0", ir[0], ir[1]);
      miscompares++;
    end
    step();
    vectors++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ir[0] !== 1'b1 || ir[1] !== 1'b0) begin
      $display("FAIL bubble1: valid=%b/%b in_ready=%b/%b, required 0/0 1/0", ov[0], ov[1], ir[0], ir[1]);
      miscompares++;
    end
    step();
    vectors++;
    if (ov[0] !== 1'b1 || rss[0] !== 3'd2 || dsts[0] !== 3'd4 || isl[0] !== 1'b0 ||
        ov[1] !== 1'b0 || ir[1] !== 1'b1) begin
      $display("FAIL bubble2: valid=%b/%b dst0=%0d in_ready1=%b, required 1/0 dst 4 ready 1",
               ov[0], ov[1], dsts[0], ir[1]);
      miscompares++;
    end
    step();
    vectors++;
    if (ov[1] !== 1'b1 || dsts[1] !== 3'd4) begin
      $display("FAIL two_bubble_issue: valid=%b dst=%0d, required 1 dst 4", ov[1], dsts[1]);
      miscompares++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_hold_refresh();
    out_ready = 0;
    set_instr(3'd1, 1, 3'd5, 1, 3'd6, 1, 0);
    step();
    idle_inputs();
    wb_we = 1; wb_sel = 3'd5; wb_data = 16'hBEEF;
    #1;
    vectors++;
    if (ir[0] !== 1'b0) begin
      $display("FAIL hold_in_ready: in_ready=%b, required 0", ir[0]);
      miscompares++;
    end
    step();
    wb_we = 0;
    vectors++;
    if (ov[0] !== 1'b1 || rtd[0] !== 16'hBEEF || rsd[0] !== 16'h0 || rts[0] !== 3'd5) begin
      $display("FAIL hold_refresh: valid=%b rt=%h rs=%h, required 1/beef/0000", ov[0], rtd[0], rsd[0]);
      miscompares++;
    end
    step();
    vectors++;
    if (ov[2] !== 1'b1 || rtd[2] !== 16'hBEEF) begin
      $display("FAIL hold_steady: valid=%b rt=%h, required 1/beef", ov[2], rtd[2]);
      miscompares++;
    end
    out_ready = 1;
    step();
  endtask

  task automatic test_flush();
    set_instr(3'd0, 0, 3'd0, 0, 3'd4, 1, 1);
    step();
    set_instr(3'd4, 1, 3'd0, 0, 3'd5, 1, 0);
    flush = 1;
    #1;
    vectors++;
    if (ov[0] !== 1'b1 || ir[0] !== 1'b1 || ir[1] !== 1'b1) begin
      $display("FAIL flush_ready: valid=%b in_ready=%b/%b, required 1 1/1", ov[0], ir[0], ir[1]);
      miscompares++;
    end
    step();
    flush = 0;
    #1;
    vectors++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ir[0] !== 1'b1 || ir[1] !== 1'b1) begin
      $display("FAIL flush_clear: valid=%b/%b in_ready=%b/%b, required 0/0 1/1", ov[0], ov[1], ir[0], ir[1]);
      miscompares++;
    end
    step();
    vectors++;
    if (ov[0] !== 1'b1 || ov[1] !== 1'b1 || dsts[1] !== 3'd5) begin
      $display("FAIL post_flush_issue: valid=%b/%b dst=%0d, required 1/1 dst 5", ov[0], ov[1], dsts[1]);
      miscompares++;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_err();
    wb_we = 1; wb_sel = 3'd7; wb_data = 16'hFFFF;
    step();
    wb_we = 0;
    vectors++;
    if (er[2] !== 1'b1 || er[0] !== 1'b0) begin
      $display("FAIL err_wb_sel: err=%b/%b, required 1 (6 regs) / 0 (8 regs)", er[2], er[0]);
      miscompares++;
    end
    set_instr(3'd7, 1, 3'd5, 1, 3'd0, 0, 0);
    step();
    vectors++;
    if (ov[2] !== 1'b1 || rsd[2] !== 16'h0 || rtd[2] !== 16'hBEEF || rsd[0] !== 16'hFFFF) begin
      $display("FAIL err_no_write: rs6=%h rt6=%h rs8=%h, required 0000/beef/ffff", rsd[2], rtd[2], rsd[0]);
      miscompares++;
    end
    idle_inputs();
    step(); step();
    vectors++;
    if (er[2] !== 1'b1) begin
      $display("FAIL err_sticky: err=%b, required 1", er[2]);
      miscompares++;
    end
    rst = 1;
    step();
    rst = 0;
    vectors++;
    if (er[2] !== 1'b0) begin
      $display("FAIL err_rst: err=%b, required 0", er[2]);
      miscompares++;
    end
    set_instr(3'd0, 0, 3'd6, 1, 3'd0, 0, 0);
    step();
    idle_inputs();
    vectors++;
    if (er[2] !== 1'b1 || er[0] !== 1'b0 || ov[2] !== 1'b1 || rtd[2] !== 16'h0) begin
      $display("FAIL err_src_sel: err=%b/%b valid=%b rt=%h, required 1/0 1 0000", er[2], er[0], ov[2], rtd[2]);
      miscompares++;
    end
    step();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_hold_refresh();
    test_flush();
    test_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
